// File: rtl/mips_boot_pkg.sv
// ============================================================================
// Module   : mips_boot_pkg
// Brief    : Shared state encoding and default sizing for the MIPS boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_boot_pkg;

    localparam int unsigned C_DEF_MAX_WORDS = 256;
    localparam int unsigned C_DEF_BASE_ADDR = 0;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } boot_state_t;

    // States in which the stream port presents in_ready.
    function automatic logic is_accepting(boot_state_t s);
        return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_boot_loader.sv
// ============================================================================
// Module   : mips_boot_loader
// Brief    : Streams a program image (header N, N data words) into instruction/
//            data memory, then releases the multicycle MIPS core from reset.
// Options  : BOOT_CHECKSUM_EN - adds a trailing 32-bit wrapping-sum check word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = C_DEF_BASE_ADDR,
    parameter int unsigned MAX_WORDS = C_DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    input  logic              boot_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned       CNT_W  = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t C_ST_AFTER_LOAD = ST_CSUM;
`else
    localparam boot_state_t C_ST_AFTER_LOAD = ST_DONE;
`endif

    boot_state_t       r_state;
    boot_state_t       w_state_nxt;
    logic              w_beat;
    logic              w_last;
    logic              w_hdr_too_big;
    logic              w_release;

    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_remaining;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    assign w_beat        = in_valid & r_in_ready;
    assign w_last        = (r_remaining == CNT_W'(1));
    assign w_hdr_too_big = (in_data > 32'(MAX_WORDS));
    // Leaving LOAD delays the release one cycle so done trails the last write strobe.
    assign w_release     = (w_state_nxt == ST_DONE) && (r_state != ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_beat) begin
                    if (in_data == 32'd0) begin
                        w_state_nxt = C_ST_AFTER_LOAD;
                    end else if (w_hdr_too_big) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_beat && w_last) begin
                    w_state_nxt = C_ST_AFTER_LOAD;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (w_beat) begin
                    w_state_nxt = (in_data == r_sum) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (boot_req) begin
                    w_state_nxt = ST_HDR;
                end
            end
            default: begin
                w_state_nxt = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= C_BASE;
            r_mem_wdata <= 32'd0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_remaining <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum       <= 32'd0;
`endif
        end else begin
            r_in_ready <= is_accepting(w_state_nxt);
            r_mem_we   <= 1'b0;
            r_done     <= w_release;
            r_core_rst <= ~w_release;
            r_err      <= (w_state_nxt == ST_ERROR);

            if ((r_state == ST_HDR) && w_beat) begin
                r_remaining <= in_data[CNT_W-1:0];
                r_idx       <= '0;
`ifdef BOOT_CHECKSUM_EN
                r_sum       <= 32'd0;
`endif
            end

            if ((r_state == ST_LOAD) && w_beat) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= C_BASE + r_idx;
                r_mem_wdata <= in_data;
                r_idx       <= r_idx + ADDR_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
                r_sum       <= r_sum + in_data;
`endif
            end

            if (((r_state == ST_DONE) || (r_state == ST_ERROR)) && boot_req) begin
                r_idx <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign core_rst  = r_core_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
// ============================================================================
// Module   : tb_mips_boot_loader
// Brief    : Directed self-checking bench for mips_boot_loader (honours BOOT_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              boot_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    mips_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .MAX_WORDS (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .boot_req  (boot_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic pulse_boot_req();
        in_valid = 1'b0;
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; boot_req = 1'b0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 8'd0) begin n_errors++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
        n_checks++; if (mem_wdata !== 32'd0) begin n_errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL rst_core_held: got %b want 1", core_rst); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        w[0] = 32'hDEAD_BEEF; w[1] = 32'h1234_5678; w[2] = 32'h0BAD_F00D;
        clear_log();
        in_valid = 1'b1; in_data = 32'd3;
        tick();
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL b2b_hdr_we: got %b want 0", mem_we); end
        for (int i = 0; i < 3; i++) begin
            in_data = w[i];
            tick();
            n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL b2b_we[%0d]: got %b want 1", i, mem_we); end
            n_checks++; if (mem_addr !== 8'(i)) begin n_errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_addr, 8'(i)); end
            n_checks++; if (mem_wdata !== w[i]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_wdata, w[i]); end
        end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_early: got %b want 0", done); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL b2b_core_rst_early: got %b want 1", core_rst); end
`ifdef BOOT_CHECKSUM_EN
        in_data = 32'hDEAD_BEEF + 32'h1234_5678 + 32'h0BAD_F00D;
`else
        in_valid = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL b2b_we_after: got %b want 0", mem_we); end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %b want 1", done); end
        n_checks++; if (core_rst !== 1'b0) begin n_errors++; $display("FAIL b2b_core_rst: got %b want 0", core_rst); end
        tick();
        n_checks++; if (log_addr.size() != 3) begin n_errors++; $display("FAIL b2b_write_count: got %0d want 3", log_addr.size()); end
    endtask

    task automatic test_gapped();
        logic [31:0] s[5];
        int nw;
        s[0] = 32'd3; s[1] = 32'hA5A5_0001; s[2] = 32'h5A5A_0002; s[3] = 32'hFFFF_FFFF;
        s[4] = 32'hA5A5_0001 + 32'h5A5A_0002 + 32'hFFFF_FFFF;
`ifdef BOOT_CHECKSUM_EN
        nw = 5;
`else
        nw = 4;
`endif
        pulse_boot_req();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL gap_boot_done: got %b want 0", done); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL gap_boot_core_rst: got %b want 1", core_rst); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL gap_boot_ready: got %b want 1", in_ready); end
        clear_log();
        for (int k = 0; k < nw; k++) begin
            in_valid = 1'b1; in_data = s[k];
            tick();
            in_valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
                tick();
                n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL gap_extra_we[%0d.%0d]: got %b want 0", k, g, mem_we); end
                if (k < nw - 1) begin
                    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL gap_ready[%0d.%0d]: got %b want 1", k, g, in_ready); end
                end
            end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL gap_done: got %b want 1", done); end
        n_checks++; if (core_rst !== 1'b0) begin n_errors++; $display("FAIL gap_core_rst: got %b want 0", core_rst); end
        n_checks++;
        if (log_addr.size() != 3) begin
            n_errors++; $display("FAIL gap_write_count: got %0d want 3", log_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (log_addr[i] !== 8'(i) || log_data[i] !== s[i+1]) begin
                    n_errors++; $display("FAIL gap_write[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 8'(i), s[i+1]);
                end
            end
        end
    endtask

    task automatic test_zero_header();
        pulse_boot_req();
        clear_log();
        in_valid = 1'b1; in_data = 32'd0;
        tick();
`ifdef BOOT_CHECKSUM_EN
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL zero_csum_ready: got %b want 1", in_ready); end
        in_data = 32'd0;
        tick();
`endif
        in_valid = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL zero_done: got %b want 1", done); end
        n_checks++; if (core_rst !== 1'b0) begin n_errors++; $display("FAIL zero_core_rst: got %b want 0", core_rst); end
        tick();
        n_checks++; if (log_addr.size() != 0) begin n_errors++; $display("FAIL zero_writes: got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_oversize();
        pulse_boot_req();
        clear_log();
        in_valid = 1'b1; in_data = 32'd300;
        tick();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL big_err: got %b want 1", err); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL big_core_rst: got %b want 1", core_rst); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL big_ready: got %b want 0", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL big_done: got %b want 0", done); end
        in_data = 32'h0000_0055;
        tick();
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL big_no_write: got %b want 0", mem_we); end
        pulse_boot_req();
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL big_boot_err: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL big_boot_ready: got %b want 1", in_ready); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL big_boot_core_rst: got %b want 1", core_rst); end
        in_valid = 1'b1; in_data = 32'd257;
        tick();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL hdr257_err: got %b want 1", err); end
        pulse_boot_req();
        in_valid = 1'b1; in_data = 32'd256;
        tick();
        in_valid = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL hdr256_err: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL hdr256_ready: got %b want 1", in_ready); end
        tick();
        n_checks++; if (log_addr.size() != 0) begin n_errors++; $display("FAIL big_writes: got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_rst_mid_load();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_log();
        in_valid = 1'b1; in_data = 32'd4;
        tick();
        in_data = 32'h0000_0011;
        tick();
        in_data = 32'h0000_0022;
        tick();
        rst = 1'b1; in_data = 32'h0000_0033;
        tick();
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL mid_rst_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 8'd0) begin n_errors++; $display("FAIL mid_rst_addr: got %h want 00", mem_addr); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL mid_rst_core_rst: got %b want 1", core_rst); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_ready_after: got %b want 1", in_ready); end
        n_checks++; if (log_addr.size() != 2) begin n_errors++; $display("FAIL mid_rst_writes: got %0d want 2", log_addr.size()); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_done: got %b want 0", done); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] s[5];
        s[0] = 32'd3; s[1] = 32'd1; s[2] = 32'd2; s[3] = 32'd3; s[4] = 32'd6;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = s[k];
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL csum_ok_done: got %b want 1", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL csum_ok_err: got %b want 0", err); end
        pulse_boot_req();
        s[4] = 32'd7;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = s[k];
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL csum_bad_err: got %b want 1", err); end
        n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL csum_bad_core_rst: got %b want 1", core_rst); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL csum_bad_done: got %b want 0", done); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; boot_req = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_zero_header();
        test_oversize();
        test_rst_mid_load();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
